// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the ID/EX register and the iterative
// RV32M multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_in;
    logic            flush_in;
    logic [2:0]      op_in;
    logic [XLEN-1:0] rs1Data_in;
    logic [XLEN-1:0] rs2Data_in;
    logic            rdE_in;
    logic [4:0]      rdIdx_in;
    logic            busy_out;
    logic            stall_out;
    logic            done_out;
    logic [XLEN-1:0] result_out;
    logic            rdE_out;
    logic [4:0]      rdIdx_out;

    modport master (
        output start_in, flush_in, op_in, rs1Data_in, rs2Data_in, rdE_in, rdIdx_in,
        input  busy_out, stall_out, done_out, result_out, rdE_out, rdIdx_out
    );

    modport slave (
        input  start_in, flush_in, op_in, rs1Data_in, rs2Data_in, rdE_in, rdIdx_in,
        output busy_out, stall_out, done_out, result_out, rdE_out, rdIdx_out
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, sign fix-up on the final step.
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    localparam int CW = $clog2(ITER);

    state_e            state_q, state_d;
    op_e               op_q, op_new;
    logic [XLEN-1:0]   acc_hi_q, acc_lo_q, opnd_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, rem_neg_q, rde_q;
    logic [4:0]        idx_q;
    logic [XLEN-1:0]   result_q;
    logic              rde_out_q;
    logic [4:0]        idx_out_q;

    logic              a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;

    always_comb begin
        op_new      = op_e'(bus.op_in);
        a_signed    = op_new inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed    = op_new inside {OP_MULH, OP_DIV, OP_REM};
        a_neg       = a_signed & bus.rs1Data_in[XLEN-1];
        b_neg       = b_signed & bus.rs2Data_in[XLEN-1];
        a_mag       = a_neg ? -bus.rs1Data_in : bus.rs1Data_in;
        b_mag       = b_neg ? -bus.rs2Data_in : bus.rs2Data_in;
        is_div      = bus.op_in[2];
        div_zero    = is_div && (bus.rs2Data_in == '0);
        div_ovf     = (op_new == OP_DIV || op_new == OP_REM)
                      && (bus.rs1Data_in == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.rs2Data_in == '1);
        special     = div_zero || div_ovf;
        special_val = '0;
        // op_in[1] separates the remainder ops from the quotient ops
        if (div_zero)
            special_val = bus.op_in[1] ? bus.rs1Data_in : '1;
        else if (div_ovf)
            special_val = bus.op_in[1] ? '0 : bus.rs1Data_in;
    end

    // acc_hi/acc_lo hold {product} for multiply and {remainder, dividend/quotient} for divide
    logic [XLEN:0]     mul_sum, div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo, quo_fix, rem_fix, final_val;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_trial = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge    = div_trial >= {1'b0, opnd_q};
        if (op_q[2]) begin
            step_hi = div_ge ? XLEN'(div_trial - {1'b0, opnd_q}) : div_trial[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = rem_neg_q ? -step_hi : step_hi;
        case (op_q)
            OP_MUL:                       final_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_val = quo_fix;
            default:                      final_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_in) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == CW'(ITER - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_in) state_d = IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            op_q      <= OP_MUL;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            rde_q     <= 1'b0;
            idx_q     <= '0;
            result_q  <= '0;
            rde_out_q <= 1'b0;
            idx_out_q <= '0;
        end else if (bus.flush_in) begin
            rde_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_in) begin
                    op_q      <= op_new;
                    rde_q     <= bus.rdE_in;
                    idx_q     <= bus.rdIdx_in;
                    cnt_q     <= '0;
                    acc_hi_q  <= '0;
                    acc_lo_q  <= is_div ? a_mag : b_mag;
                    opnd_q    <= is_div ? b_mag : a_mag;
                    neg_q     <= a_neg ^ b_neg;
                    rem_neg_q <= a_neg;
                    if (special) begin
                        result_q  <= special_val;
                        rde_out_q <= bus.rdE_in;
                        idx_out_q <= bus.rdIdx_in;
                    end
                end
                CALC: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        result_q  <= final_val;
                        rde_out_q <= rde_q;
                        idx_out_q <= idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out   = (state_q != IDLE);
    assign bus.stall_out  = (state_q == IDLE && bus.start_in && !bus.flush_in) || (state_q == CALC);
    assign bus.done_out   = (state_q == DONE);
    assign bus.result_out = result_q;
    assign bus.rdE_out    = rde_out_q;
    assign bus.rdIdx_out  = idx_out_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed checks of ex_muldiv: results, latency, stall window, special
// cases, ignored restart, flush and mid-operation reset.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_result = '0;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // inj_kind: 0 none, 1 restart attempt, 2 flush, 3 reset (applied at cycle inj_at after start)
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rde, input logic [4:0] idx,
                          input logic [31:0] expv, input int lat_exp, input int inj_at,
                          input int inj_kind);
        int   lat = 1;
        int   stalls;
        logic seen = 1'b0;
        @(negedge clk);
        bus.op_in      = op;
        bus.rs1Data_in = a;
        bus.rs2Data_in = b;
        bus.rdE_in     = rde;
        bus.rdIdx_in   = idx;
        bus.start_in   = 1'b1;
        #1 stalls = bus.stall_out ? 1 : 0;
        @(negedge clk);
        bus.start_in   = 1'b0;
        bus.op_in      = 3'b000;
        bus.rs1Data_in = 32'd1000;
        bus.rs2Data_in = 32'd3;
        bus.rdE_in     = 1'b0;
        bus.rdIdx_in   = 5'd31;
        while (!bus.done_out && lat < 40) begin
            if (bus.stall_out) stalls++;
            if (lat == inj_at && inj_kind >= 2) begin
                if (inj_kind == 2) bus.flush_in = 1'b1;
                else               rst = 1'b1;
                @(negedge clk);
                bus.flush_in = 1'b0;
                rst = 1'b0;
                check({tag, " busy"}, 32'(bus.busy_out), 32'd0);
                check({tag, " done"}, 32'(bus.done_out), 32'd0);
                check({tag, " rdE_out"}, 32'(bus.rdE_out), 32'd0);
                if (inj_kind == 2) begin
                    check({tag, " result held"}, bus.result_out, last_result);
                end else begin
                    check({tag, " result"}, bus.result_out, 32'd0);
                    check({tag, " rdIdx_out"}, 32'(bus.rdIdx_out), 32'd0);
                    check({tag, " stall"}, 32'(bus.stall_out), 32'd0);
                    last_result = '0;
                end
                repeat (40) begin
                    @(negedge clk);
                    if (bus.done_out) seen = 1'b1;
                end
                check({tag, " no late done"}, 32'(seen), 32'd0);
                return;
            end
            bus.start_in = (inj_kind == 1 && lat == inj_at);
            @(negedge clk);
            lat++;
        end
        bus.start_in = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " stall cycles"}, 32'(stalls), 32'(lat_exp));
        check({tag, " done"}, 32'(bus.done_out), 32'd1);
        check({tag, " result"}, bus.result_out, expv);
        check({tag, " rdE_out"}, 32'(bus.rdE_out), 32'(rde));
        check({tag, " rdIdx_out"}, 32'(bus.rdIdx_out), 32'(idx));
        check({tag, " stall at done"}, 32'(bus.stall_out), 32'd0);
        last_result = expv;
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(bus.done_out), 32'd0);
        check({tag, " busy after"}, 32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_in   = 1'b0;
        bus.flush_in   = 1'b0;
        bus.op_in      = 3'b000;
        bus.rs1Data_in = '0;
        bus.rs2Data_in = '0;
        bus.rdE_in     = 1'b0;
        bus.rdIdx_in   = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy_out), 32'd0);
        check("reset stall", 32'(bus.stall_out), 32'd0);
        check("reset done", 32'(bus.done_out), 32'd0);
        check("reset result", bus.result_out, 32'd0);
        check("reset rdE", 32'(bus.rdE_out), 32'd0);
        check("reset rdIdx", 32'(bus.rdIdx_out), 32'd0);
        rst = 1'b0;

        run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 1'b1, 5'd5,  32'hFFFFFFEB, 33, 0, 0);
        run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 1'b1, 5'd6,  32'h40000000, 33, 0, 0);
        run_op("mulh neg", 3'b001, 32'hFFFFFFFF, 32'd2,        1'b1, 5'd7,  32'hFFFFFFFF, 33, 0, 0);
        run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd8,  32'hFFFFFFFF, 33, 0, 0);
        run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd9,  32'hFFFFFFFE, 33, 0, 0);
        run_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        1'b1, 5'd10, 32'hFFFFFFFD, 33, 0, 0);
        run_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        1'b1, 5'd11, 32'hFFFFFFFF, 33, 0, 0);
        run_op("div negb", 3'b100, 32'd7,        32'hFFFFFFFE, 1'b1, 5'd12, 32'hFFFFFFFD, 33, 0, 0);
        run_op("rem negb", 3'b110, 32'd7,        32'hFFFFFFFE, 1'b1, 5'd13, 32'd1,        33, 0, 0);
        run_op("divu",     3'b101, 32'd100,      32'd7,        1'b1, 5'd14, 32'd14,       33, 0, 0);
        run_op("remu",     3'b111, 32'd100,      32'd7,        1'b1, 5'd15, 32'd2,        33, 0, 0);
        run_op("divu by0", 3'b101, 32'd5,        32'd0,        1'b1, 5'd16, 32'hFFFFFFFF, 1,  0, 0);
        run_op("remu by0", 3'b111, 32'd5,        32'd0,        1'b1, 5'd17, 32'd5,        1,  0, 0);
        run_op("rem by0",  3'b110, 32'hFFFFFFFB, 32'd0,        1'b1, 5'd18, 32'hFFFFFFFB, 1,  0, 0);
        run_op("div ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1, 5'd19, 32'h80000000, 1,  0, 0);
        run_op("rem ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1, 5'd20, 32'd0,        1,  0, 0);
        run_op("restart",  3'b100, 32'd100,      32'd7,        1'b1, 5'd21, 32'd14,       33, 10, 1);
        run_op("flush",    3'b000, 32'd5,        32'd6,        1'b1, 5'd22, 32'd30,       33, 12, 2);
        run_op("post flush", 3'b000, 32'd9,      32'd9,        1'b1, 5'd23, 32'd81,       33, 0, 0);
        run_op("reset mid", 3'b100, 32'd1000,    32'd3,        1'b1, 5'd24, 32'd333,      33, 20, 3);
        run_op("post reset", 3'b000, 32'd3,      32'd4,        1'b1, 5'd25, 32'd12,       33, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
